// File: rtl/op_arb_pkg.sv
// ----------------------------------------------------------------------------
// op_arb_pkg : opcode and state encodings shared by the arbiter and op_unit.
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package op_arb_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_LT   = 4'd4,
    OP_EQ   = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_RAND = 4'd9,
    OP_RXOR = 4'd10,
    OP_LAND = 4'd11,
    OP_CAT  = 4'd12,
    OP_MAX  = 4'd13
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/op_unit.sv
// ----------------------------------------------------------------------------
// op_unit  : combinational W-bit multi-function operator; opcodes 14/15 flag err.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module op_unit
  import op_arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [OP_W-1:0] op_i,
  input  logic [W-1:0]    a_i,
  input  logic [W-1:0]    b_i,
  output logic [W-1:0]    result_o,
  output logic            err_o
);

  localparam int SHW = $clog2(W);
  localparam int HW  = W / 2;

  logic [SHW-1:0] shamt;
  assign shamt = b_i[SHW-1:0];

  always_comb begin
    result_o = '0;
    err_o    = 1'b0;
    case (op_e'(op_i))
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_SHL:  result_o = a_i << shamt;
      OP_SHR:  result_o = a_i >> shamt;
      OP_LT:   result_o = W'(a_i < b_i);
      OP_EQ:   result_o = W'(a_i == b_i);
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_RAND: result_o = W'(&a_i);
      OP_RXOR: result_o = W'(^a_i);
      OP_LAND: result_o = W'((|a_i) && (|b_i));
      OP_CAT:  result_o = {a_i[HW-1:0], b_i[HW-1:0]};
      OP_MAX:  result_o = (a_i > b_i) ? a_i : b_i;
      default: err_o    = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/op_unit_arbiter.sv
// ----------------------------------------------------------------------------
// op_unit_arbiter : shares one op_unit among NREQ requesters (IDLE/EXEC/RESP).
// Round-robin by default; ARB_FIXED_PRIO_EN selects lowest-index-wins.
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module op_unit_arbiter
  import op_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OP_W-1:0] req_op,
  input  logic [NREQ*W-1:0]    req_a,
  input  logic [NREQ*W-1:0]    req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [W-1:0]         rsp_result,
  output logic                 rsp_err,
  output logic                 busy
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_EXEC = EXEC;
  localparam logic [1:0] S_RESP = RESP;

  // First requester with valid set, searching upward from last+1 with wrap.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] cand;
    logic [IDW-1:0] pick;
    logic           found;
    cand  = last;
    pick  = last;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!found && valid[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [OP_W-1:0] op_arr [NREQ];
  logic [W-1:0]    a_arr  [NREQ];
  logic [W-1:0]    b_arr  [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[g*OP_W +: OP_W];
    assign a_arr[g]  = req_a[g*W +: W];
    assign b_arr[g]  = req_b[g*W +: W];
  end

  logic [1:0]      state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [W-1:0]    result_q, result_d;
  logic            err_q, err_d;

  logic [IDW-1:0]  winner;
  logic            any_valid;
  logic            accept;
  logic [W-1:0]    unit_result;
  logic            unit_err;

  assign any_valid = |req_valid;
  assign accept    = (state_q == S_IDLE) && any_valid;

`ifdef ARB_FIXED_PRIO_EN
  // Searching from NREQ-1 makes index 0 the first candidate: lowest index wins.
  assign winner = rr_pick(req_valid, IDW'(NREQ - 1));
`else
  logic [IDW-1:0] last_grant_q, last_grant_d;

  assign winner       = rr_pick(req_valid, last_grant_q);
  assign last_grant_d = accept ? winner : last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= IDW'(NREQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  op_unit #(
    .W (W)
  ) u_op_unit (
    .op_i     (op_q),
    .a_i      (a_q),
    .b_i      (b_q),
    .result_o (unit_result),
    .err_o    (unit_err)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          op_d    = op_arr[winner];
          a_d     = a_arr[winner];
          b_d     = b_arr[winner];
          id_d    = winner;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = unit_result;
        err_d    = unit_err;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign req_ready  = accept ? (NREQ'(1) << winner) : '0;
  assign rsp_valid  = (state_q == S_RESP);
  assign busy       = (state_q != S_IDLE);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_err    = err_q;

endmodule

`default_nettype wire

// File: tb/tb_op_unit_arbiter.sv
// ----------------------------------------------------------------------------
// tb_op_unit_arbiter : randomized + directed bench with queue scoreboard.
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_op_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int W     = 4;
  localparam int IDW   = $clog2(NREQ);
  localparam int MOD   = 1 << W;
  localparam int SHMOD = 1 << $clog2(W);
  localparam int HMOD  = 1 << (W / 2);

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*4-1:0] req_op;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_err;
  logic              busy;

  op_unit_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int result;
    int err;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference semantics written directly from the opcode table.
  function automatic exp_t model_op(input int id, input int op, input int a, input int b);
    exp_t   e;
    longint sh;
    e.id     = id;
    e.err    = 0;
    e.result = 0;
    sh       = longint'(1) << (b % SHMOD);
    case (op)
      0:  e.result = (a + b) % MOD;
      1:  e.result = (a - b + MOD) % MOD;
      2:  e.result = int'((longint'(a) * sh) % MOD);
      3:  e.result = int'(longint'(a) / sh);
      4:  e.result = (a < b) ? 1 : 0;
      5:  e.result = (a == b) ? 1 : 0;
      6:  e.result = a & b;
      7:  e.result = a | b;
      8:  e.result = a ^ b;
      9:  e.result = (a == MOD - 1) ? 1 : 0;
      10: e.result = $countones(a) % 2;
      11: e.result = (a != 0 && b != 0) ? 1 : 0;
      12: e.result = (a % HMOD) * HMOD + (b % HMOD);
      13: e.result = (a > b) ? a : b;
      default: e.err = 1;
    endcase
    return e;
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] v, input int last);
    int sel;
    sel = -1;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--)
      if (v[i]) sel = i;
`else
    for (int k = NREQ; k >= 1; k--)
      if (v[(last + k) % NREQ]) sel = (last + k) % NREQ;
`endif
    return sel;
  endfunction

  // Transaction-level model: one in flight, response two cycles after grant.
  int m_busy = 0;
  int m_age  = 0;
  int m_last = NREQ - 1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0;
        m_age  = 0;
        m_last = NREQ - 1;
        sb.delete();
      end else begin
        logic [NREQ-1:0] exp_ready;
        int              w;
        exp_ready = '0;
        w         = -1;
        if (m_busy == 0 && req_valid != '0) begin
          w            = model_pick(req_valid, m_last);
          exp_ready[w] = 1'b1;
        end
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        check("busy", 32'(busy), 32'(m_busy != 0));
        check("rsp_valid", 32'(rsp_valid), 32'(m_busy != 0 && m_age >= 2));
        if (w >= 0) begin
          sb.push_back(model_op(w, int'(req_op[w*4 +: 4]), int'(req_a[w*W +: W]),
                                int'(req_b[w*W +: W])));
          m_busy = 1;
          m_age  = 1;
          m_last = w;
        end else if (m_busy != 0) begin
          if (m_age >= 2 && rsp_ready) m_busy = 0;
          else m_age++;
        end
      end
    end
  end

  // Response monitor: compares every presented response against the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL rsp_unexpected: id=%0d result=%0h with nothing outstanding at %0t",
                   rsp_id, rsp_result, $time);
        end else begin
          check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
          check("rsp_result", 32'(rsp_result), 32'(sb[0].result));
          check("rsp_err", 32'(rsp_err), 32'(sb[0].err));
          if (rsp_ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int id, input int op, input int a, input int b);
    logic got;
    got                = 1'b0;
    req_op[id*4 +: 4]  = 4'(op);
    req_a[id*W +: W]   = W'(a);
    req_b[id*W +: W]   = W'(b);
    req_valid[id]      = 1'b1;
    for (int k = 0; k < 32 && !got; k++) begin
      @(negedge clk);
      got = req_ready[id];
    end
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: requester %0d not accepted within 32 cycles", id);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'(0));
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(0));
    check({tag, "_rsp_id"}, 32'(rsp_id), 32'(0));
    check({tag, "_rsp_result"}, 32'(rsp_result), 32'(0));
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    idle(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Every opcode from requester 0 with a=1100, b=0110, then EQ on equal operands.
    for (int op = 0; op < 16; op++) issue(0, op, 12, 6);
    issue(0, 5, 12, 12);
    idle(4);

    // All requesters valid continuously: rotating grants.
    for (int i = 0; i < NREQ; i++) begin
      req_op[i*4 +: 4] = 4'(i);
      req_a[i*W +: W]  = W'(i + 5);
      req_b[i*W +: W]  = W'(3);
    end
    req_valid = '1;
    idle(16);
    req_valid = '0;
    idle(4);

    // Consumer stalls for five RESP cycles.
    issue(2, 8, 9, 3);
    rsp_ready = 1'b0;
    idle(6);
    rsp_ready = 1'b1;
    idle(4);

    // Reset during EXEC discards the transaction; arbitration restarts at 0.
    issue(1, 0, 7, 5);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    req_op[0*4 +: 4] = 4'd7;
    req_a[0*W +: W]  = W'(3);
    req_b[0*W +: W]  = W'(8);
    req_op[2*4 +: 4] = 4'd13;
    req_a[2*W +: W]  = W'(2);
    req_b[2*W +: W]  = W'(11);
    req_valid        = 4'b0101;
    idle(2);
    rst_n = 1'b1;
    idle(8);
    req_valid = '0;
    idle(4);

    // Requesters 1 and 3 held valid.
    req_valid = 4'b1010;
    idle(12);
    req_valid = '0;
    idle(4);

    // Randomized traffic with random consumer back-pressure.
    repeat (400) begin
      req_valid = NREQ'($urandom);
      req_op    = (NREQ*4)'($urandom);
      req_a     = (NREQ*W)'($urandom);
      req_b     = (NREQ*W)'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      idle(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    idle(10);
    check("sb_drain", 32'(sb.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
